// File: rtl/mem_stage_dump.sv
// MIPS data-memory stage: byte/half/word loads and stores with sign or zero
// extension, misalignment flagging, and a dump engine that streams every
// memory word to the debug unit over a valid/ready handshake.
module mem_stage_dump #(
  parameter int NB_DATA  = 32,
  parameter int NB_ADDR  = 7,
  parameter int NB_BADDR = NB_ADDR + 2
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                en_pipeline_i,
  input  logic [NB_BADDR-1:0] addr_i,
  input  logic [NB_DATA-1:0]  data_wr_i,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic [1:0]          mem_size_i,
  input  logic                mem_unsigned_i,
  output logic [NB_DATA-1:0]  data_read_o,
  output logic                misaligned_o,
  input  logic                dbg_start_i,
  input  logic                dbg_ready_i,
  output logic                dbg_valid_o,
  output logic [NB_ADDR-1:0]  dbg_addr_o,
  output logic [NB_DATA-1:0]  dbg_data_o,
  output logic                dbg_busy_o,
  output logic                dbg_done_o
);

  localparam int DEPTH = 2 ** NB_ADDR;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DUMP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [NB_ADDR-1:0] LAST_PTR = {NB_ADDR{1'b1}};

  logic [NB_DATA-1:0] mem_q [DEPTH];

  logic [1:0]         state_q, state_d;
  logic [NB_ADDR-1:0] ptr_q, ptr_d;
  logic [NB_DATA-1:0] data_read_q, data_read_d;
  logic               misaligned_q, misaligned_d;

  logic               busy;
  logic               acc;
  logic               bad;
  logic [NB_ADDR-1:0] word_idx;
  logic [NB_DATA-1:0] rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [NB_DATA-1:0] ld_data;
  logic               wr_en;
  logic [3:0]         wr_mask;
  logic [NB_DATA-1:0] wr_data;

  assign busy     = (state_q != ST_IDLE);
  assign word_idx = addr_i[NB_BADDR-1:2];
  assign rd_word  = mem_q[word_idx];

  // Access qualification, alignment check and load lane extraction/extension
  always_comb begin
    acc = en_pipeline_i & (mem_read_i | mem_write_i) & ~busy;
    bad = 1'b0;
    case (mem_size_i)
      2'b01:   bad = addr_i[0];
      2'b10:   bad = (addr_i[1:0] != 2'b00);
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase

    rd_byte = rd_word[7:0];
    case (addr_i[1:0])
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      2'd3:    rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
    rd_half = addr_i[1] ? rd_word[31:16] : rd_word[15:0];

    case (mem_size_i)
      2'b00:   ld_data = {{24{~mem_unsigned_i & rd_byte[7]}}, rd_byte};
      2'b01:   ld_data = {{16{~mem_unsigned_i & rd_half[15]}}, rd_half};
      default: ld_data = rd_word;
    endcase

    data_read_d  = (acc & mem_read_i & ~bad) ? ld_data : data_read_q;
    misaligned_d = acc & bad;
  end

  // Store lane mask and lane-replicated store data
  always_comb begin
    wr_en   = acc & mem_write_i & ~bad;
    wr_mask = 4'b0000;
    wr_data = data_wr_i;
    case (mem_size_i)
      2'b00: begin
        wr_mask = 4'b0001 << addr_i[1:0];
        wr_data = {4{data_wr_i[7:0]}};
      end
      2'b01: begin
        wr_mask = addr_i[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{data_wr_i[15:0]}};
      end
      2'b10: begin
        wr_mask = 4'b1111;
        wr_data = data_wr_i;
      end
      default: begin
        wr_mask = 4'b0000;
        wr_data = data_wr_i;
      end
    endcase
  end

  // Dump engine next-state: walk every word once, then pulse done
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        ptr_d = '0;
        if (dbg_start_i) begin
          state_d = ST_DUMP;
        end
      end
      ST_DUMP: begin
        if (dbg_ready_i) begin
          if (ptr_q == LAST_PTR) begin
            state_d = ST_DONE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Pipeline result registers and dump FSM state
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      data_read_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      data_read_q  <= data_read_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Data memory: cleared on reset, byte-lane writes otherwise
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_mask[k]) begin
          mem_q[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  assign data_read_o  = data_read_q;
  assign misaligned_o = misaligned_q;
  assign dbg_valid_o  = (state_q == ST_DUMP);
  assign dbg_busy_o   = busy;
  assign dbg_done_o   = (state_q == ST_DONE);
  assign dbg_addr_o   = ptr_q;
  assign dbg_data_o   = mem_q[ptr_q];

endmodule

// File: tb/tb_mem_stage_dump.sv
// Directed self-checking bench for mem_stage_dump.
module tb_mem_stage_dump;

  localparam int NB_DATA  = 32;
  localparam int NB_ADDR  = 7;
  localparam int NB_BADDR = 9;
  localparam int DEPTH    = 128;

  logic                clock_i = 1'b0;
  logic                reset_i;
  logic                en_pipeline_i;
  logic [NB_BADDR-1:0] addr_i;
  logic [NB_DATA-1:0]  data_wr_i;
  logic                mem_read_i;
  logic                mem_write_i;
  logic [1:0]          mem_size_i;
  logic                mem_unsigned_i;
  logic [NB_DATA-1:0]  data_read_o;
  logic                misaligned_o;
  logic                dbg_start_i;
  logic                dbg_ready_i;
  logic                dbg_valid_o;
  logic [NB_ADDR-1:0]  dbg_addr_o;
  logic [NB_DATA-1:0]  dbg_data_o;
  logic                dbg_busy_o;
  logic                dbg_done_o;

  int checks   = 0;
  int failures = 0;

  mem_stage_dump #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_BADDR(NB_BADDR)) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .en_pipeline_i  (en_pipeline_i),
    .addr_i         (addr_i),
    .data_wr_i      (data_wr_i),
    .mem_read_i     (mem_read_i),
    .mem_write_i    (mem_write_i),
    .mem_size_i     (mem_size_i),
    .mem_unsigned_i (mem_unsigned_i),
    .data_read_o    (data_read_o),
    .misaligned_o   (misaligned_o),
    .dbg_start_i    (dbg_start_i),
    .dbg_ready_i    (dbg_ready_i),
    .dbg_valid_o    (dbg_valid_o),
    .dbg_addr_o     (dbg_addr_o),
    .dbg_data_o     (dbg_data_o),
    .dbg_busy_o     (dbg_busy_o),
    .dbg_done_o     (dbg_done_o)
  );

  always #5 clock_i = ~clock_i;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // One pipeline access cycle, then the request lines drop
  task automatic access(input logic rd, input logic wr, input logic [1:0] size,
                        input logic uns, input logic [8:0] addr, input logic [31:0] wdata);
    mem_read_i     = rd;
    mem_write_i    = wr;
    mem_size_i     = size;
    mem_unsigned_i = uns;
    addr_i         = addr;
    data_wr_i      = wdata;
    tick();
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({data_read_o, misaligned_o, dbg_valid_o, dbg_addr_o, dbg_busy_o, dbg_done_o} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got data=%h mis=%b v=%b a=%0d busy=%b done=%b want all 0",
               data_read_o, misaligned_o, dbg_valid_o, dbg_addr_o, dbg_busy_o, dbg_done_o);
    end
    access(1'b1, 1'b0, 2'b10, 1'b0, 9'h000, 32'h0);
    checks++;
    if (data_read_o !== 32'h0 || misaligned_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_lw0 got data=%h mis=%b want 00000000 0", data_read_o, misaligned_o);
    end
  endtask

  task automatic test_word();
    access(1'b1, 1'b0, 2'b10, 1'b0, 9'h000, 32'h0);
    access(1'b0, 1'b1, 2'b10, 1'b0, 9'h008, 32'hDEADBEEF);
    checks++;
    if (data_read_o !== 32'h0) begin
      failures++;
      $display("[TB] FAIL sw_no_read got %h want 00000000", data_read_o);
    end
    access(1'b1, 1'b0, 2'b10, 1'b0, 9'h008, 32'h0);
    checks++;
    if (data_read_o !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL lw_08 got %h want DEADBEEF", data_read_o);
    end
  endtask

  task automatic test_byte_half();
    access(1'b0, 1'b1, 2'b00, 1'b0, 9'h009, 32'h000000F0);
    access(1'b1, 1'b0, 2'b00, 1'b0, 9'h009, 32'h0);
    checks++;
    if (data_read_o !== 32'hFFFFFFF0) begin
      failures++;
      $display("[TB] FAIL lb_09 got %h want FFFFFFF0", data_read_o);
    end
    access(1'b1, 1'b0, 2'b00, 1'b1, 9'h009, 32'h0);
    checks++;
    if (data_read_o !== 32'h000000F0) begin
      failures++;
      $display("[TB] FAIL lbu_09 got %h want 000000F0", data_read_o);
    end
    access(1'b1, 1'b0, 2'b01, 1'b0, 9'h00A, 32'h0);
    checks++;
    if (data_read_o !== 32'hFFFFDEAD) begin
      failures++;
      $display("[TB] FAIL lh_0a got %h want FFFFDEAD", data_read_o);
    end
    access(1'b1, 1'b0, 2'b01, 1'b1, 9'h00A, 32'h0);
    checks++;
    if (data_read_o !== 32'h0000DEAD) begin
      failures++;
      $display("[TB] FAIL lhu_0a got %h want 0000DEAD", data_read_o);
    end
    access(1'b1, 1'b0, 2'b01, 1'b0, 9'h008, 32'h0);
    checks++;
    if (data_read_o !== 32'hFFFFF0EF) begin
      failures++;
      $display("[TB] FAIL lh_08 got %h want FFFFF0EF", data_read_o);
    end
    access(1'b1, 1'b0, 2'b10, 1'b1, 9'h008, 32'h0);
    checks++;
    if (data_read_o !== 32'hDEADF0EF) begin
      failures++;
      $display("[TB] FAIL lw_08_merged got %h want DEADF0EF", data_read_o);
    end
    access(1'b0, 1'b1, 2'b01, 1'b0, 9'h00E, 32'hCAFE8001);
    access(1'b1, 1'b0, 2'b10, 1'b0, 9'h00C, 32'h0);
    checks++;
    if (data_read_o !== 32'h80010000) begin
      failures++;
      $display("[TB] FAIL sh_0e got %h want 80010000", data_read_o);
    end
  endtask

  task automatic test_misaligned();
    access(1'b0, 1'b1, 2'b10, 1'b0, 9'h000, 32'h11223344);
    access(1'b0, 1'b1, 2'b01, 1'b0, 9'h003, 32'h00001234);
    checks++;
    if (misaligned_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sh_03_flag got %b want 1", misaligned_o);
    end
    access(1'b1, 1'b0, 2'b10, 1'b0, 9'h000, 32'h0);
    checks++;
    if (data_read_o !== 32'h11223344 || misaligned_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sh_03_dropped got data=%h mis=%b want 11223344 0", data_read_o, misaligned_o);
    end
    access(1'b1, 1'b0, 2'b10, 1'b0, 9'h00A, 32'h0);
    checks++;
    if (data_read_o !== 32'h11223344 || misaligned_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL lw_0a got data=%h mis=%b want 11223344 1", data_read_o, misaligned_o);
    end
    access(1'b1, 1'b0, 2'b11, 1'b0, 9'h000, 32'h0);
    checks++;
    if (data_read_o !== 32'h11223344 || misaligned_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL size_11 got data=%h mis=%b want 11223344 1", data_read_o, misaligned_o);
    end
    en_pipeline_i = 1'b0;
    access(1'b1, 1'b1, 2'b11, 1'b0, 9'h000, 32'h55555555);
    checks++;
    if (misaligned_o !== 1'b0 || data_read_o !== 32'h11223344) begin
      failures++;
      $display("[TB] FAIL disabled got data=%h mis=%b want 11223344 0", data_read_o, misaligned_o);
    end
    access(1'b0, 1'b1, 2'b10, 1'b0, 9'h000, 32'h55555555);
    en_pipeline_i = 1'b1;
    access(1'b1, 1'b0, 2'b10, 1'b0, 9'h000, 32'h0);
    checks++;
    if (data_read_o !== 32'h11223344) begin
      failures++;
      $display("[TB] FAIL disabled_write got %h want 11223344", data_read_o);
    end
  endtask

  task automatic test_read_before_write();
    access(1'b1, 1'b1, 2'b10, 1'b0, 9'h000, 32'hA5A5A5A5);
    checks++;
    if (data_read_o !== 32'h11223344) begin
      failures++;
      $display("[TB] FAIL rbw_old got %h want 11223344", data_read_o);
    end
    access(1'b1, 1'b0, 2'b10, 1'b0, 9'h000, 32'h0);
    checks++;
    if (data_read_o !== 32'hA5A5A5A5) begin
      failures++;
      $display("[TB] FAIL rbw_new got %h want A5A5A5A5", data_read_o);
    end
  endtask

  task automatic test_dump();
    int hs;
    int done_cnt;
    int iter;
    bit finished;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      access(1'b0, 1'b1, 2'b10, 1'b0, 9'(i * 4), 32'(i * 4));
    end
    dbg_start_i = 1'b1;
    dbg_ready_i = 1'b0;
    tick();
    dbg_start_i = 1'b0;
    checks++;
    if (dbg_valid_o !== 1'b1 || dbg_busy_o !== 1'b1 || dbg_addr_o !== 7'd0) begin
      failures++;
      $display("[TB] FAIL dump_start got v=%b busy=%b a=%0d want 1 1 0", dbg_valid_o, dbg_busy_o, dbg_addr_o);
    end
    hs = 0;
    done_cnt = 0;
    finished = 1'b0;
    iter = 0;
    while (!finished && iter < 1000) begin
      dbg_ready_i = ~dbg_ready_i;
      if (iter == 3) begin
        mem_write_i = 1'b1;
        mem_size_i  = 2'b10;
        addr_i      = 9'h010;
        data_wr_i   = 32'h00000BAD;
        en_pipeline_i = 1'b1;
      end else begin
        mem_write_i = 1'b0;
      end
      if (dbg_valid_o && dbg_ready_i) begin
        checks++;
        if (dbg_addr_o !== 7'(hs) || dbg_data_o !== 32'(hs * 4)) begin
          failures++;
          $display("[TB] FAIL dump_word got a=%0d d=%h want a=%0d d=%h",
                   dbg_addr_o, dbg_data_o, hs, hs * 4);
        end
        hs++;
      end
      if (dbg_done_o) done_cnt++;
      if (done_cnt > 0 && !dbg_busy_o) finished = 1'b1;
      if (!finished) tick();
      iter++;
    end
    mem_write_i = 1'b0;
    dbg_ready_i = 1'b0;
    checks++;
    if (hs != DEPTH || done_cnt != 1 || dbg_busy_o !== 1'b0 || !finished) begin
      failures++;
      $display("[TB] FAIL dump_totals got hs=%0d done=%0d busy=%b fin=%b want 128 1 0 1",
               hs, done_cnt, dbg_busy_o, finished);
    end
    access(1'b1, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0);
    checks++;
    if (data_read_o !== 32'h00000010) begin
      failures++;
      $display("[TB] FAIL dump_write_blocked got %h want 00000010", data_read_o);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cycles;
    dbg_ready_i = 1'b1;
    dbg_start_i = 1'b1;
    tick();
    busy_cycles = 0;
    while (dbg_busy_o && busy_cycles < 1000) begin
      busy_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles != DEPTH + 1) begin
      failures++;
      $display("[TB] FAIL b2b_duration got busy=%0d want %0d", busy_cycles, DEPTH + 1);
    end
    tick();
    checks++;
    if (dbg_valid_o !== 1'b1 || dbg_addr_o !== 7'd0) begin
      failures++;
      $display("[TB] FAIL held_start_restart got v=%b a=%0d want 1 0", dbg_valid_o, dbg_addr_o);
    end
    dbg_start_i = 1'b0;
    dbg_ready_i = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid_dump();
    int guard;
    access(1'b0, 1'b1, 2'b10, 1'b0, 9'h008, 32'h12345678);
    dbg_ready_i = 1'b1;
    dbg_start_i = 1'b1;
    tick();
    dbg_start_i = 1'b0;
    guard = 0;
    while (dbg_addr_o != 7'd5 && guard < 50) begin
      tick();
      guard++;
    end
    dbg_ready_i = 1'b0;
    checks++;
    if (dbg_addr_o !== 7'd5 || dbg_valid_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_reach got a=%0d v=%b want 5 1", dbg_addr_o, dbg_valid_o);
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checks++;
    if (dbg_valid_o !== 1'b0 || dbg_busy_o !== 1'b0 || dbg_done_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset got v=%b busy=%b done=%b want 0 0 0", dbg_valid_o, dbg_busy_o, dbg_done_o);
    end
    access(1'b1, 1'b0, 2'b10, 1'b0, 9'h008, 32'h0);
    checks++;
    if (data_read_o !== 32'h0) begin
      failures++;
      $display("[TB] FAIL mid_reset_mem got %h want 00000000", data_read_o);
    end
    dbg_start_i = 1'b1;
    tick();
    dbg_start_i = 1'b0;
    checks++;
    if (dbg_valid_o !== 1'b1 || dbg_addr_o !== 7'd0) begin
      failures++;
      $display("[TB] FAIL restart got v=%b a=%0d want 1 0", dbg_valid_o, dbg_addr_o);
    end
  endtask

  initial begin
    reset_i        = 1'b1;
    en_pipeline_i  = 1'b1;
    addr_i         = '0;
    data_wr_i      = '0;
    mem_read_i     = 1'b0;
    mem_write_i    = 1'b0;
    mem_size_i     = 2'b10;
    mem_unsigned_i = 1'b0;
    dbg_start_i    = 1'b0;
    dbg_ready_i    = 1'b0;
    #1;
    test_reset();
    test_word();
    test_byte_half();
    test_misaligned();
    test_read_before_write();
    test_dump();
    test_back_to_back();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
